// File: rtl/kp_feeder.sv
// Keypoint feeder: FIFO between the descriptor stage and the matcher, with flag/next and end/ack handshakes.
// Build option KP_FEEDER_SCORE_FILTER_EN discards keypoints scoring below MIN_SCORE before the FIFO.
module kp_feeder #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  MIN_SCORE = 8'd0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_frame_end,
  input  logic [9:0]               i_coor_x,
  input  logic [9:0]               i_coor_y,
  input  logic [7:0]               i_score,
  input  logic [255:0]             i_descriptor,
  output logic                     o_flag,
  output logic [9:0]               o_coor_x,
  output logic [9:0]               o_coor_y,
  output logic [7:0]               o_score,
  output logic [255:0]             o_descriptor,
  input  logic                     i_next,
  output logic                     o_end,
  input  logic                     i_end,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_drop_cnt,
  output logic                     o_eof_lost,
  output logic [15:0]              o_frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

`ifdef KP_FEEDER_SCORE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic [DEPTH-1:0] kp_mem;
  logic [DEPTH-1:0] eof_mem;
  logic [9:0]       x_mem     [DEPTH];
  logic [9:0]       y_mem     [DEPTH];
  logic [7:0]       score_mem [DEPTH];
  logic [255:0]     desc_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;
  logic [AW:0]   count;
  logic [15:0]   drop_cnt;
  logic [15:0]   frame_cnt;
  logic          eof_lost;

  logic score_ok;
  logic kp_in;
  logic full;
  logic not_empty;
  logic head_kp;
  logic head_eof;
  logic push;
  logic merge_eof;
  logic flag_take;
  logic end_take;
  logic clear_kp;
  logic pop;

  always_comb begin
    score_ok  = ~FILTER_EN | (i_score >= MIN_SCORE);
    kp_in     = i_valid & score_ok;
    full      = (count == FULL_LVL);
    not_empty = (count != '0);
    tail_ptr  = wr_ptr - 1'b1;
    head_kp   = not_empty & kp_mem[rd_ptr];
    head_eof  = not_empty & eof_mem[rd_ptr];
    push      = (kp_in | i_frame_end) & ~full;
    // A full FIFO still records the frame end by folding it into the newest entry.
    merge_eof = full & i_frame_end & ~eof_mem[tail_ptr];
    flag_take = head_kp & i_next;
    end_take  = ~head_kp & head_eof & i_end;
    clear_kp  = flag_take & head_eof;
    pop       = (flag_take & ~head_eof) | end_take;
  end

  always_comb begin
    o_flag       = head_kp;
    o_end        = ~head_kp & head_eof;
    o_coor_x     = head_kp ? x_mem[rd_ptr]     : '0;
    o_coor_y     = head_kp ? y_mem[rd_ptr]     : '0;
    o_score      = head_kp ? score_mem[rd_ptr] : '0;
    o_descriptor = head_kp ? desc_mem[rd_ptr]  : '0;
    o_level      = count;
    o_drop_cnt   = drop_cnt;
    o_eof_lost   = eof_lost;
    o_frame_cnt  = frame_cnt;
  end

  // Storage is not reset; occupancy gates every read, so stale contents are invisible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      kp_mem[wr_ptr]    <= kp_in;
      eof_mem[wr_ptr]   <= i_frame_end;
      x_mem[wr_ptr]     <= i_coor_x;
      y_mem[wr_ptr]     <= i_coor_y;
      score_mem[wr_ptr] <= i_score;
      desc_mem[wr_ptr]  <= i_descriptor;
    end
    if (merge_eof) eof_mem[tail_ptr] <= 1'b1;
    if (clear_kp)  kp_mem[rd_ptr]    <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
      eof_lost  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (full && kp_in && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (full && i_frame_end && eof_mem[tail_ptr]) eof_lost <= 1'b1;
      if (end_take) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_kp_feeder.sv
// Bench for kp_feeder: queue-based reference model compared against every output each cycle, plus directed checks.
module tb_kp_feeder;

  localparam int         DEPTH     = 4;
  localparam logic [7:0] MIN_SCORE = 8'd10;
  localparam int         LW        = $clog2(DEPTH) + 1;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_valid = 1'b0;
  logic           i_frame_end = 1'b0;
  logic [9:0]     i_coor_x = '0;
  logic [9:0]     i_coor_y = '0;
  logic [7:0]     i_score = '0;
  logic [255:0]   i_descriptor = '0;
  logic           i_next = 1'b0;
  logic           i_end = 1'b0;
  logic           o_flag;
  logic [9:0]     o_coor_x;
  logic [9:0]     o_coor_y;
  logic [7:0]     o_score;
  logic [255:0]   o_descriptor;
  logic           o_end;
  logic [LW-1:0]  o_level;
  logic [15:0]    o_drop_cnt;
  logic           o_eof_lost;
  logic [15:0]    o_frame_cnt;

  kp_feeder #(.DEPTH(DEPTH), .MIN_SCORE(MIN_SCORE)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_frame_end  (i_frame_end),
    .i_coor_x     (i_coor_x),
    .i_coor_y     (i_coor_y),
    .i_score      (i_score),
    .i_descriptor (i_descriptor),
    .o_flag       (o_flag),
    .o_coor_x     (o_coor_x),
    .o_coor_y     (o_coor_y),
    .o_score      (o_score),
    .o_descriptor (o_descriptor),
    .i_next       (i_next),
    .o_end        (o_end),
    .i_end        (i_end),
    .o_level      (o_level),
    .o_drop_cnt   (o_drop_cnt),
    .o_eof_lost   (o_eof_lost),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         kp;
    logic         eof;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [7:0]   s;
    logic [255:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_drop = '0;
  logic [15:0] m_frame = '0;
  logic        m_lost = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    ent_t h;
    logic ef, ee;
    h  = '0;
    ef = 1'b0;
    ee = 1'b0;
    if (mq.size() > 0) begin
      h  = mq[0];
      ef = h.kp;
      ee = ~h.kp & h.eof;
    end
    check_val("flag",  o_flag, ef);
    check_val("end",   o_end,  ee);
    check_val("x",     o_coor_x,     ef ? h.x : 10'd0);
    check_val("y",     o_coor_y,     ef ? h.y : 10'd0);
    check_val("score", o_score,      ef ? h.s : 8'd0);
    check_val("desc",  o_descriptor, ef ? h.d : 256'd0);
    check_val("level", o_level,      mq.size());
    check_val("drop",  o_drop_cnt,   m_drop);
    check_val("lost",  o_eof_lost,   m_lost);
    check_val("frame", o_frame_cnt,  m_frame);
  endtask

  task automatic model_update();
    logic kp_in, full, h_kp, h_eof;
    ent_t e;
    if (i_rst) begin
      mq.delete();
      m_drop  = '0;
      m_frame = '0;
      m_lost  = 1'b0;
      return;
    end
`ifdef KP_FEEDER_SCORE_FILTER_EN
    kp_in = i_valid && (i_score >= MIN_SCORE);
`else
    kp_in = i_valid;
`endif
    full  = (mq.size() == DEPTH);
    h_kp  = 1'b0;
    h_eof = 1'b0;
    if (mq.size() > 0) begin
      h_kp  = mq[0].kp;
      h_eof = mq[0].eof;
    end
    if (full) begin
      if (kp_in && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      if (i_frame_end) begin
        if (mq[$].eof) m_lost = 1'b1;
        else           mq[$].eof = 1'b1;
      end
    end else if (kp_in || i_frame_end) begin
      e = '{kp: kp_in, eof: i_frame_end, x: i_coor_x, y: i_coor_y, s: i_score, d: i_descriptor};
      mq.push_back(e);
    end
    if (h_kp && i_next) begin
      if (h_eof) mq[0].kp = 1'b0;
      else       void'(mq.pop_front());
    end else if (!h_kp && h_eof && i_end) begin
      void'(mq.pop_front());
      m_frame = m_frame + 16'd1;
    end
  endtask

  // One clock: drive inputs, compare state at the falling edge, advance the model at the rising edge.
  task automatic step(input logic rs, input logic v, input logic fe, input logic [9:0] x,
                      input logic [7:0] s, input logic nx, input logic ed);
    i_rst        = rs;
    i_valid      = v;
    i_frame_end  = fe;
    i_coor_x     = x;
    i_coor_y     = x + 10'd100;
    i_score      = s;
    i_descriptor = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    i_next       = nx;
    i_end        = ed;
    @(negedge i_clk);
    compare_all();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge i_clk);
    model_update();
    #1;
    step(0, 0, 0, 0, 0, 0, 0);
    check_val("rst_level", o_level, 0);
    check_val("rst_flag", o_flag, 0);

    // three keypoints then a standalone frame end
    step(0, 1, 0, 10'd1, 8'd21, 1, 0);
    step(0, 1, 0, 10'd2, 8'd22, 1, 0);
    step(0, 1, 0, 10'd3, 8'd23, 1, 0);
    step(0, 0, 1, 10'd0, 8'd0,  1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0);
    check_val("t1_end_held", o_end, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check_val("t1_frame", o_frame_cnt, 1);
    check_val("t1_level", o_level, 0);

    // hold-off: data must stay put while i_next is low
    step(0, 1, 0, 10'd5, 8'd55, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 0);
    check_val("t2_x_held", o_coor_x, 5);
    step(0, 0, 0, 0, 0, 1, 0);
    check_val("t2_level", o_level, 0);

    // keypoint carrying the frame end
    step(0, 1, 1, 10'd7, 8'd77, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_val("t3_end", o_end, 1);
    check_val("t3_flag", o_flag, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check_val("t3_frame", o_frame_cnt, 2);

    // overflow: six writes into four entries, then frame ends
    for (int i = 0; i < 6; i++) step(0, 1, 0, 10'(10 + i), 8'(40 + i), 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check_val("t4_level", o_level, 4);
    check_val("t4_drop", o_drop_cnt, 2);
    check_val("t4_lost0", o_eof_lost, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check_val("t4_lost1", o_eof_lost, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0);
    check_val("t4_end", o_end, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check_val("t4_frame", o_frame_cnt, 3);

    // next frame's keypoint waits behind a pending end request
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 10'd9, 8'd99, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);
    check_val("t5_flag_blocked", o_flag, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check_val("t5_flag", o_flag, 1);
    check_val("t5_x", o_coor_x, 9);
    step(0, 0, 0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0), 10'($urandom),
           8'($urandom), ($urandom_range(0, 4) < 3), ($urandom_range(0, 1) == 1));

    // reset in the middle of an offer
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 10'(30 + i), 8'(60 + i), 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_val("t6_flag", o_flag, 1);
    check_val("t6_level", o_level, 3);
    step(1, 1, 0, 10'd44, 8'd44, 1, 0);
    check_val("t6_rst_flag", o_flag, 0);
    check_val("t6_rst_end", o_end, 0);
    check_val("t6_rst_level", o_level, 0);
    check_val("t6_rst_x", o_coor_x, 0);
    check_val("t6_rst_desc", o_descriptor, 0);
    check_val("t6_rst_drop", o_drop_cnt, 0);
    check_val("t6_rst_lost", o_eof_lost, 0);
    check_val("t6_rst_frame", o_frame_cnt, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1, 1);

    // low-score keypoint
    step(0, 1, 0, 10'd11, 8'd5, 0, 0);
`ifdef KP_FEEDER_SCORE_FILTER_EN
    check_val("t7_level", o_level, 0);
`else
    check_val("t7_level", o_level, 1);
`endif
    check_val("t7_drop", o_drop_cnt, 0);
    step(0, 1, 0, 10'd12, 8'd10, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
